// File: rtl/rr_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux_pkg
//  Description : Shared defaults, FSM state encoding and width helpers for
//                the round-robin N:1 output multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_mux_pkg;

    localparam int c_DEF_N = 4;
    localparam int c_DEF_W = 8;

    // LOCK only occurs in builds with packet lock enabled.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FULL = 2'd1,
        LOCK = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage : rr_mux_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Rotating priority encoder; returns the first set request
//                bit found searching ptr+1, ptr+2, ... modulo N.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] idx_o,
    output logic          vld_o
);

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin : p_pick
        int c;
        idx_o = '0;
        vld_o = 1'b0;
        c     = 0;
        for (int k = N; k >= 1; k--) begin
            c = (int'(ptr_i) + k) % N;
            if (req_i[c]) begin
                idx_o = PW'(c);
                vld_o = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/rr_mux_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux_arb
//  Description : Round-robin N:1 multiplexer with a registered, back-pressured
//                output word. Define RR_MUX_LOCK_EN to hold the grant on one
//                channel until its end-of-packet word has been taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arb
    import rr_mux_pkg::*;
#(
    parameter int N = c_DEF_N,
    parameter int W = c_DEF_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              req,
    input  logic [N*W-1:0]            din,
    input  logic [N-1:0]              last,
    output logic [N-1:0]              ack,
    output logic [W-1:0]              dout,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic [sel_width(N)-1:0]   sel
);

    localparam int SW = sel_width(N);

    state_t          state_q, state_d;
    logic [W-1:0]    dout_q,  dout_d;
    logic [SW-1:0]   sel_q,   sel_d;
    logic [SW-1:0]   ptr_q,   ptr_d;

    logic [N-1:0]    w_elig;
    logic [SW-1:0]   w_idx;
    logic            w_vld;
    logic            w_can_load;

`ifdef RR_MUX_LOCK_EN
    // Persists through IDLE so a stalled packet keeps its channel reserved.
    logic            lock_q, lock_d;

    assign w_elig = lock_q ? (req & (N'(1) << ptr_q)) : req;
`else
    logic            w_unused_last;

    assign w_elig        = req;
    assign w_unused_last = ^last;
`endif

    assign w_can_load = (state_q == IDLE) || dout_ready;

    rr_pick #(
        .N  (N),
        .PW (SW)
    ) u_pick (
        .req_i (w_elig),
        .ptr_i (ptr_q),
        .idx_o (w_idx),
        .vld_o (w_vld)
    );

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        ack     = '0;
`ifdef RR_MUX_LOCK_EN
        lock_d  = lock_q;
`endif
        if (!rst && w_can_load) begin
            if (w_vld) begin
                ack[w_idx] = 1'b1;
                dout_d     = din[w_idx*W +: W];
                sel_d      = w_idx;
                ptr_d      = w_idx;
                state_d    = FULL;
`ifdef RR_MUX_LOCK_EN
                if (!last[w_idx]) begin
                    state_d = LOCK;
                    lock_d  = 1'b1;
                end else begin
                    lock_d  = 1'b0;
                end
`endif
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dout_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= SW'(N - 1);
`ifdef RR_MUX_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
`ifdef RR_MUX_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign sel        = sel_q;
    assign dout_valid = (state_q != IDLE);

endmodule : rr_mux_arb
`default_nettype wire

// File: tb/tb_rr_mux_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_mux_arb
//  Description : Directed scoreboard bench for rr_mux_arb (N=4, W=8, default
//                build without RR_MUX_LOCK_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  last;
    logic [3:0]  ack;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [1:0]  sel;

    int          checks;
    int          failures;
    logic [9:0]  exp_q[$];

    rr_mux_arb #(
        .N (4),
        .W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .din        (din),
        .last       (last),
        .ack        (ack),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .sel        (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every word accepted downstream must match the queue head.
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got dout=%0h sel=%0d expected none", dout, sel);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                chk("word_dout", {24'h0, dout}, {24'h0, e[9:2]});
                chk("word_sel",  {30'h0, sel},  {30'h0, e[1:0]});
            end
        end
    end

    // One clock: check ack (and optionally the held output) at the negedge,
    // record the word a grant will produce, then return just after posedge.
    task automatic cyc(input logic [3:0] e_ack, input bit push, input logic [7:0] p_d,
                       input logic [1:0] p_s, input bit chk_out, input logic e_v,
                       input logic [7:0] e_d, input logic [1:0] e_s);
        @(negedge clk);
        chk("ack", {28'h0, ack}, {28'h0, e_ack});
        if (chk_out) begin
            chk("dout_valid", {31'h0, dout_valid}, {31'h0, e_v});
            chk("dout",       {24'h0, dout},       {24'h0, e_d});
            chk("sel",        {30'h0, sel},        {30'h0, e_s});
        end
        if (push) exp_q.push_back({p_d, p_s});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        req        = 4'b1111;
        din        = {8'h44, 8'h33, 8'h22, 8'h11};
        last       = 4'b0010;
        dout_ready = 1'b1;

        // Reset held with all channels requesting
        cyc(4'b0000, 0, 8'h00, 2'd0, 1, 1'b0, 8'h00, 2'd0);
        cyc(4'b0000, 0, 8'h00, 2'd0, 1, 1'b0, 8'h00, 2'd0);
        rst = 1'b0;

        // Round-robin sweep with wrap back to channel 0
        cyc(4'b0001, 1, 8'h11, 2'd0, 1, 1'b0, 8'h00, 2'd0);
        cyc(4'b0010, 1, 8'h22, 2'd1, 1, 1'b1, 8'h11, 2'd0);
        cyc(4'b0100, 1, 8'h33, 2'd2, 0, 1'b0, 8'h00, 2'd0);
        cyc(4'b1000, 1, 8'h44, 2'd3, 0, 1'b0, 8'h00, 2'd0);
        cyc(4'b0001, 1, 8'h11, 2'd0, 0, 1'b0, 8'h00, 2'd0);

        // Backpressure while 22 is held, then load without a gap
        cyc(4'b0010, 1, 8'h22, 2'd1, 0, 1'b0, 8'h00, 2'd0);
        dout_ready = 1'b0;
        repeat (3) cyc(4'b0000, 0, 8'h00, 2'd0, 1, 1'b1, 8'h22, 2'd1);
        dout_ready = 1'b1;
        cyc(4'b0100, 1, 8'h33, 2'd2, 1, 1'b1, 8'h22, 2'd1);
        req = 4'b0000;
        cyc(4'b0000, 0, 8'h00, 2'd0, 1, 1'b1, 8'h33, 2'd2);
        cyc(4'b0000, 0, 8'h00, 2'd0, 1, 1'b0, 8'h33, 2'd2);

        // Sparse requests and wrap from channel 3
        req = 4'b1000;
        cyc(4'b1000, 1, 8'h44, 2'd3, 0, 1'b0, 8'h00, 2'd0);
        req = 4'b0100;
        cyc(4'b0100, 1, 8'h33, 2'd2, 0, 1'b0, 8'h00, 2'd0);
        req = 4'b1001;
        cyc(4'b1000, 1, 8'h44, 2'd3, 0, 1'b0, 8'h00, 2'd0);
        cyc(4'b0001, 1, 8'h11, 2'd0, 0, 1'b0, 8'h00, 2'd0);
        req = 4'b0000;
        cyc(4'b0000, 0, 8'h00, 2'd0, 0, 1'b0, 8'h00, 2'd0);
        cyc(4'b0000, 0, 8'h00, 2'd0, 1, 1'b0, 8'h11, 2'd0);

        // Without packet lock, last is ignored: channel 1 is not held
        req = 4'b1111;
        cyc(4'b0010, 1, 8'h22, 2'd1, 0, 1'b0, 8'h00, 2'd0);
        cyc(4'b0100, 1, 8'h33, 2'd2, 0, 1'b0, 8'h00, 2'd0);
        cyc(4'b1000, 1, 8'h44, 2'd3, 0, 1'b0, 8'h00, 2'd0);
        req = 4'b0000;
        cyc(4'b0000, 0, 8'h00, 2'd0, 0, 1'b0, 8'h00, 2'd0);
        cyc(4'b0000, 0, 8'h00, 2'd0, 1, 1'b0, 8'h44, 2'd3);

        // Reset while a word is held under backpressure; it must never be taken
        dout_ready = 1'b0;
        req = 4'b0010;
        cyc(4'b0010, 0, 8'h00, 2'd0, 0, 1'b0, 8'h00, 2'd0);
        rst = 1'b1;
        req = 4'b1010;
        cyc(4'b0000, 0, 8'h00, 2'd0, 1, 1'b1, 8'h22, 2'd1);
        rst = 1'b0;
        dout_ready = 1'b1;
        cyc(4'b0010, 1, 8'h22, 2'd1, 1, 1'b0, 8'h00, 2'd0);
        req = 4'b0000;
        cyc(4'b0000, 0, 8'h00, 2'd0, 1, 1'b1, 8'h22, 2'd1);
        cyc(4'b0000, 0, 8'h00, 2'd0, 1, 1'b0, 8'h22, 2'd1);

        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rr_mux_arb
`default_nettype wire

// File: doc/rr_mux_arb.md
RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 Parameter N, default 4, number of source channels (2..16).
REQ-002 Parameter W, default 8, data width per channel.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  N  per-channel valid; req[i]=1 means din slice i holds a word.
REQ-006 din  input  N*W  flattened channel data; channel i in bits [i*W +: W].
REQ-007 last  input  N  per-channel end-of-packet flag; used only when RR_MUX_LOCK_EN is defined, otherwise ignored.
REQ-008 ack  output  N  one-hot, combinational; ack[i]=1 in the cycle channel i's word is captured.
REQ-009 dout  output  W  registered selected word to the downstream 2:1/N:1 consumer.
REQ-010 dout_valid  output  1  dout holds an unconsumed word.
REQ-011 dout_ready  input  1  downstream accepts dout when dout_valid=1 and dout_ready=1.
REQ-012 sel  output  clog2(N)  index of the channel whose word is in dout.

Function
REQ-013 Output register "can load" when dout_valid=0, or dout_valid=1 and dout_ready=1 in the same cycle.
REQ-014 When can load and any req bit is set, the block shall grant the first requesting channel searching ptr+1, ptr+2, ... modulo N.
REQ-015 On grant g: ack[g]=1 that cycle; at the next edge dout<=din[g], sel<=g, dout_valid<=1, ptr<=g.
REQ-016 When can load and req=0: dout_valid<=0 at next edge if drained; dout, sel, ptr hold.
REQ-017 When dout_valid=1 and dout_ready=0: ack=0, dout, sel, dout_valid and ptr hold.
REQ-018 Latency req-to-dout_valid is exactly 1 cycle; sustained throughput one word per cycle with dout_ready held high.
REQ-019 Simultaneous drain and load in one cycle shall not drop or duplicate a word.
REQ-020 ack shall have at most one bit set and never set a bit whose req is 0.
REQ-021 Wrap-around: after grant to channel N-1 search restarts at channel 0.
REQ-022 FSM states: IDLE (dout_valid=0), FULL (dout_valid=1), LOCK (FULL with packet lock, macro only); transitions per REQ-013..REQ-017 and REQ-027.

Reset
REQ-023 While rst=1: ack=0 combinationally; at the edge dout_valid<=0, dout<=0, sel<=0, ptr<=N-1, state<=IDLE.
REQ-024 Reset mid-transfer shall discard the held word; the first grant after reset goes to the lowest-indexed requester.

Configuration
REQ-025 Macro RR_MUX_LOCK_EN enables packet lock.
REQ-026 Without RR_MUX_LOCK_EN: re-arbitration after every accepted word; last ignored; LOCK state absent.
REQ-027 With RR_MUX_LOCK_EN: a grant to g with last[g]=0 enters LOCK; only channel g is eligible until a word with last[g]=1 is granted, then ptr<=g and normal arbitration resumes; req[g]=0 while locked stalls the output (no other channel granted).

Structure
REQ-028 Shared package rr_mux_pkg shall hold default N and W, state encoding constants (IDLE, FULL, LOCK) and a clog2 function.
REQ-029 One combinational sub-module rr_pick (rotating priority encoder: req, ptr -> grant index, grant-valid) shall be instantiated once.

Verification (N=4, W=8)
REQ-030 Reset: rst=1 two cycles with req=4'b1111 -> ack=0, dout_valid=0, dout=0; release -> first ack=4'b0001, dout=din[0] one cycle later.
REQ-031 Round-robin: req=4'b1111, dout_ready=1, din={8'h44,8'h33,8'h22,8'h11} -> dout sequence 11,22,33,44,11 on consecutive cycles, sel 0,1,2,3,0.
REQ-032 Backpressure: dout=8'h22 valid, dout_ready=0 three cycles -> dout, sel stable, ack=0; on dout_ready=1 next word loads same cycle, no gap.
REQ-033 Sparse/wrap: ptr=3, req=4'b0100 -> ack=4'b0100, sel=2; then req=4'b1001 -> ack=4'b1000, then 4'b0001.
REQ-034 Lock (macro defined): channel 1 sends 3 words with last=0,0,1 while req=4'b1111 -> sel=1 for all 3, then sel=2; without macro -> sel 1,2,3.
REQ-035 Mid-operation reset: rst asserted while dout_valid=1, dout_ready=0 -> dout_valid=0 next cycle, held word never presented.
